mult_add_fix_pipe: RTL and testbench
====================================

Name: mult_add_fix_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8-bit x4 multiply-add primitive used by the conv kernels' HDL library.
- Computes dot product of LANES DATA_W-bit lane pairs, with optional running accumulation and output saturation.
- Honours the library's ivalid/iready/ovalid/oready stall interface rather than tying handshakes off.

Parameters:
- DATA_W, 8, width of each lane operand.
- LANES, 4, number of multiply lanes (1..16).
- OUT_W, 32, result width (must be >= 2*DATA_W+clog2(LANES)).
- SIGNED, 1, 1 = two's-complement operands/result, 0 = unsigned.

Ports:
- clock  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ivalid  in  1  upstream item valid.
- iready  in  1  downstream ready to take result.
- ovalid  out  1  result valid.
- oready  out  1  block can accept an item this cycle.
- dataa  in  LANES*DATA_W  packed lane operands A, lane 0 in LSBs.
- datab  in  LANES*DATA_W  packed lane operands B.
- accum  in  1  1 = add this dot product to accumulator; 0 = start new sum.
- result  out  OUT_W  dot product / accumulated value.

Behaviour:
- Reset (async, resetn=0): v1=v2=v3=0, ovalid=0, result=0, accumulator=0. Release takes effect on next edge; in-flight items are discarded.
- Pipeline: S1 registers products p[i]=a[i]*b[i] (2*DATA_W, sign per SIGNED) plus accum flag. S2 registers adder-tree sum (2*DATA_W+clog2(LANES), sign-extended). S3 registers result. Latency 3 cycles from accepted input to ovalid with iready held 1.
- Per-stage elastic advance:
  - load3 = v2 & (iready | ~v3)
  - load2 = v1 & (~v2 | load3)
  - load1 = ivalid & oready
  - oready = ~v1 | load2 (combinational from iready).
- Valid bits:
  - v3 clears when iready & ~load3.
  - v2 clears when load3 & ~load2.
  - v1 clears when load2 & ~load1.
- Input handshake: item accepted only when ivalid & oready; ivalid with oready=0 has no effect. Upstream must hold data.
- Output handshake: result/ovalid held stable while ovalid & ~iready.
- Accumulation, at load3:
  - sum = (S2.accum ? acc : 0) + S2.sum, computed at OUT_W+1 bits.
  - Saturate to signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1] (SIGNED=1) or [0, 2^OUT_W-1] (SIGNED=0).
  - result and acc both load the saturated value.
- Accumulator changes only on load3; stalls never double-add.
- Bubbles (ivalid=0) do not disturb acc. accum=1 on first item after reset adds to 0.
- Simultaneous: a stage may load and drain in the same cycle, giving full throughput of 1 item/cycle with iready=1.
- Without accumulation no overflow is possible, given the OUT_W constraint.

Test Plan:
- Reset then a=[1,2,3,4], b=[5,6,7,8], accum=0, iready=1 -> ovalid 3 cycles later, result=70, then ovalid=0.
- SIGNED=1: a=[-128×4], b=[-128×4] -> result=65536. a=[-1,2,-3,4], b=[1,1,1,1] -> result=2.
- Stream of 3 items with accum=0,1,1, each dot=100 -> results 100, 200, 300, back-to-back on consecutive cycles.
- OUT_W=18, repeated accum=1 of dot 65536 -> results 65536, 131071 (saturated), 131071. Negative variant saturates at -131072.
- iready=0 for 5 cycles with 4 items offered:
  - pipeline fills; oready drops after 3 accepted items.
  - result held constant while stalled.
  - each result emitted exactly once when iready returns; acc unchanged by the stall.
- Assert resetn=0 mid-stream with 2 items in flight -> ovalid=0, result=0 immediately. After release, a new item with accum=1 and dot 7 -> result=7.

Source files
------------

// File: rtl/mult_add_fix_pipe_if.sv
// Handshake and data bundle for mult_add_fix_pipe.
// master drives items and downstream ready; slave is the pipeline itself.
interface mult_add_fix_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned OUT_W  = 32
);
    logic                      ivalid;
    logic                      iready;
    logic                      ovalid;
    logic                      oready;
    logic [LANES*DATA_W-1:0]   dataa;
    logic [LANES*DATA_W-1:0]   datab;
    logic                      accum;
    logic [OUT_W-1:0]          result;

    modport master (
        output ivalid, iready, dataa, datab, accum,
        input  ovalid, oready, result
    );

    modport slave (
        input  ivalid, iready, dataa, datab, accum,
        output ovalid, oready, result
    );
endinterface

// File: rtl/mult_add_fix_pipe.sv
// Three-stage elastic dot-product unit: lane products, adder tree, then
// saturating accumulate into the result/accumulator registers.
module mult_add_fix_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned OUT_W  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                clock,
    input  logic                resetn,
    mult_add_fix_pipe_if.slave  bus_io
);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam int unsigned SumW  = ProdW + $clog2(LANES);
    localparam int unsigned AccW  = OUT_W + 1;

    localparam logic [OUT_W-1:0] SatMax = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SatMin = {1'b1, {(OUT_W-1){1'b0}}};

    logic load1, load2, load3, oready;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    logic [LANES-1:0][ProdW-1:0] prod_q, prod_d;
    logic                        flag1_q, flag1_d;
    logic [SumW-1:0]             sum_q, sum_d;
    logic                        flag2_q, flag2_d;
    logic [OUT_W-1:0]            result_q, result_d;
    logic [OUT_W-1:0]            acc_q, acc_d;

    logic [DATA_W-1:0] a_lane, b_lane;
    logic [ProdW-1:0]  a_ext, b_ext;
    logic [SumW-1:0]   p_ext;
    logic [AccW-1:0]   acc_ext, sum_ext, total;
    logic [OUT_W-1:0]  sat;

    // Elastic advance: each stage loads when the next one frees up this cycle.
    always_comb begin
        load3  = v2_q & (bus_io.iready | ~v3_q);
        load2  = v1_q & (~v2_q | load3);
        oready = ~v1_q | load2;
        load1  = bus_io.ivalid & oready;
        v1_d   = load1 ? 1'b1 : (load2 ? 1'b0 : v1_q);
        v2_d   = load2 ? 1'b1 : (load3 ? 1'b0 : v2_q);
        v3_d   = load3 ? 1'b1 : (bus_io.iready ? 1'b0 : v3_q);
    end

    always_comb begin
        prod_d  = prod_q;
        flag1_d = flag1_q;
        a_lane  = '0;
        b_lane  = '0;
        a_ext   = '0;
        b_ext   = '0;
        if (load1) begin
            flag1_d = bus_io.accum;
            for (int unsigned i = 0; i < LANES; i++) begin
                a_lane = bus_io.dataa[i*DATA_W +: DATA_W];
                b_lane = bus_io.datab[i*DATA_W +: DATA_W];
                if (SIGNED) begin
                    a_ext = ProdW'($signed(a_lane));
                    b_ext = ProdW'($signed(b_lane));
                end else begin
                    a_ext = ProdW'(a_lane);
                    b_ext = ProdW'(b_lane);
                end
                // Truncated product is exact for both signed and unsigned lanes.
                prod_d[i] = a_ext * b_ext;
            end
        end
    end

    always_comb begin
        sum_d   = sum_q;
        flag2_d = flag2_q;
        p_ext   = '0;
        if (load2) begin
            flag2_d = flag1_q;
            sum_d   = '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (SIGNED) begin
                    p_ext = SumW'($signed(prod_q[i]));
                end else begin
                    p_ext = SumW'(prod_q[i]);
                end
                sum_d = sum_d + p_ext;
            end
        end
    end

    always_comb begin
        if (SIGNED) begin
            acc_ext = AccW'($signed(acc_q));
            sum_ext = AccW'($signed(sum_q));
        end else begin
            acc_ext = AccW'(acc_q);
            sum_ext = AccW'(sum_q);
        end
        total = (flag2_q ? acc_ext : '0) + sum_ext;
        // One guard bit suffices: both addends already fit in OUT_W.
        if (SIGNED) begin
            if (total[OUT_W] != total[OUT_W-1]) begin
                sat = total[OUT_W] ? SatMin : SatMax;
            end else begin
                sat = total[OUT_W-1:0];
            end
        end else begin
            sat = total[OUT_W] ? '1 : total[OUT_W-1:0];
        end
        result_d = load3 ? sat : result_q;
        acc_d    = load3 ? sat : acc_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            prod_q   <= '0;
            flag1_q  <= 1'b0;
            sum_q    <= '0;
            flag2_q  <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            prod_q   <= prod_d;
            flag1_q  <= flag1_d;
            sum_q    <= sum_d;
            flag2_q  <= flag2_d;
            result_q <= result_d;
            acc_q    <= acc_d;
        end
    end

    assign bus_io.oready = oready;
    assign bus_io.ovalid = v3_q;
    assign bus_io.result = result_q;
endmodule

// File: tb/tb_mult_add_fix_pipe.sv
// Scoreboard bench: a 32-bit signed unit and an 18-bit signed unit for saturation.
module tb_mult_add_fix_pipe;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    mult_add_fix_pipe_if #(.DATA_W(8), .LANES(4), .OUT_W(32)) ifa ();
    mult_add_fix_pipe_if #(.DATA_W(8), .LANES(4), .OUT_W(18)) ifb ();

    mult_add_fix_pipe #(.DATA_W(8), .LANES(4), .OUT_W(32), .SIGNED(1'b1)) u_dut_a (
        .clock  (clock),
        .resetn (resetn),
        .bus_io (ifa)
    );

    mult_add_fix_pipe #(.DATA_W(8), .LANES(4), .OUT_W(18), .SIGNED(1'b1)) u_dut_b (
        .clock  (clock),
        .resetn (resetn),
        .bus_io (ifb)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_acc = 0;
    int cyc   = 0;
    logic [31:0] qa[$];
    logic [17:0] qb[$];
    int pop_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        logic [31:0] r;
        r = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
        return r;
    endfunction

    always @(negedge clock) begin
        if (resetn && ifa.ovalid && ifa.iready) begin
            if (qa.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL a_unexpected: got result 0x%0h, expected no output", ifa.result);
            end else begin
                check("a_result", 64'(ifa.result), 64'(qa.pop_front()));
                pop_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clock) begin
        if (resetn && ifb.ovalid && ifb.iready) begin
            if (qb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL b_unexpected: got result 0x%0h, expected no output", ifb.result);
            end else begin
                check("b_result", 64'(ifb.result), 64'(qb.pop_front()));
            end
        end
    end

    task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input bit acc, input longint exp);
        bit took;
        took = 1'b0;
        if (sel) begin
            ifb.ivalid = 1'b1; ifb.dataa = a; ifb.datab = b; ifb.accum = acc;
        end else begin
            ifa.ivalid = 1'b1; ifa.dataa = a; ifa.datab = b; ifa.accum = acc;
        end
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clock);
            took = sel ? ifb.oready : ifa.oready;
            @(posedge clock);
            #1;
        end
        if (took) begin
            n_acc++;
            if (sel) qb.push_back(18'(exp));
            else     qa.push_back(32'(exp));
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got oready=0 for 100 cycles, expected acceptance");
        end
        ifa.ivalid = 1'b0;
        ifb.ivalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clock);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", qa.size(), qb.size());
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        ifa.ivalid = 1'b0; ifa.iready = 1'b1; ifa.dataa = '0; ifa.datab = '0; ifa.accum = 1'b0;
        ifb.ivalid = 1'b0; ifb.iready = 1'b1; ifb.dataa = '0; ifb.datab = '0; ifb.accum = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ovalid", 64'(ifa.ovalid), 64'd0);
        check("reset_result", 64'(ifa.result), 64'd0);
        check("reset_oready", 64'(ifa.oready), 64'd1);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Basic dot product and three-cycle latency
        send(1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 70);
        @(negedge clock); check("lat_c1", 64'(ifa.ovalid), 64'd0);
        @(negedge clock); check("lat_c2", 64'(ifa.ovalid), 64'd0);
        @(negedge clock); check("lat_c3", 64'(ifa.ovalid), 64'd1);
        @(negedge clock); check("lat_c4", 64'(ifa.ovalid), 64'd0);
        drain();

        send(1'b0, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b0, 65536);
        send(1'b0, pk(-1, 2, -3, 4), pk(1, 1, 1, 1), 1'b0, 2);
        drain();

        // Back-to-back accumulation stream
        pop_cyc.delete();
        send(1'b0, pk(10, 0, 0, 0), pk(10, 0, 0, 0), 1'b0, 100);
        send(1'b0, pk(10, 0, 0, 0), pk(10, 0, 0, 0), 1'b1, 200);
        send(1'b0, pk(10, 0, 0, 0), pk(10, 0, 0, 0), 1'b1, 300);
        drain();
        check("b2b_count", 64'(pop_cyc.size()), 64'd3);
        if (pop_cyc.size() >= 3) begin
            check("b2b_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
            check("b2b_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
        end

        // Downstream stall for five cycles with four items offered
        n_acc = 0;
        ifa.iready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    send(1'b0, pk(k, 0, 0, 0), pk(1, 0, 0, 0), k > 1, longint'(k * (k + 1) / 2));
                end
            end
            begin
                repeat (3) @(negedge clock);
                @(negedge clock);
                check("stall_res_c3", 64'(ifa.result), 64'd1);
                @(negedge clock);
                check("stall_res_c4", 64'(ifa.result), 64'd1);
                check("stall_ovalid", 64'(ifa.ovalid), 64'd1);
                check("stall_oready", 64'(ifa.oready), 64'd0);
                check("stall_accepted", 64'(n_acc), 64'd3);
                @(posedge clock);
                #1;
                ifa.iready = 1'b1;
            end
        join
        drain();

        // Saturation on the 18-bit unit; first accum=1 adds to a zero accumulator
        send(1'b1, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1, 65536);
        send(1'b1, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1, 131071);
        send(1'b1, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1, 131071);
        send(1'b1, pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b0, -65024);
        send(1'b1, pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b1, -130048);
        send(1'b1, pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b1, -131072);
        send(1'b1, pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b1, -131072);
        drain();

        // Reset with two items in flight
        send(1'b0, pk(5, 0, 0, 0), pk(1, 0, 0, 0), 1'b0, 5);
        send(1'b0, pk(6, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 11);
        resetn = 1'b0;
        #1;
        check("midrst_ovalid", 64'(ifa.ovalid), 64'd0);
        check("midrst_result", 64'(ifa.result), 64'd0);
        check("midrst_oready", 64'(ifa.oready), 64'd1);
        qa.delete();
        qb.delete();
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        send(1'b0, pk(7, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
